// File: rtl/ghost_ctrl_pkg.sv
// Shared types and helpers for the ghost sprite motion controller:
// state encoding, ctrl-word layout, colour codes and the per-axis
// step/clamp function used on every move step.
package ghost_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CHASE = 2'b01,
        STUN  = 2'b10
    } state_t;

    localparam logic [1:0] COLOR_GREEN  = 2'b00;
    localparam logic [1:0] COLOR_PURPLE = 2'b01;
    localparam logic [1:0] COLOR_YELLOW = 2'b10;

    // ctrl = {color_sel[1:0], auto, id[1:0]}
    localparam int CTRL_ID_LSB    = 0;
    localparam int CTRL_AUTO_BIT  = 2;
    localparam int CTRL_COLOR_LSB = 3;

    localparam logic [1:0] BASE_ID = 2'b00;
    localparam logic [1:0] STUN_ID = 2'b11;

    function automatic logic [4:0] make_ctrl(input logic [1:0] color,
                                             input logic       auto_anim,
                                             input logic [1:0] id);
        logic [4:0] c;
        c = '0;
        c[CTRL_COLOR_LSB +: 2] = color;
        c[CTRL_AUTO_BIT]       = auto_anim;
        c[CTRL_ID_LSB +: 2]    = id;
        return c;
    endfunction

    // One move step on one axis: snap to the target when it is within
    // reach, otherwise move by spd toward it; then clamp to [0, lim].
    function automatic logic [10:0] axis_step(input logic [10:0] pos,
                                              input logic [10:0] tgt,
                                              input logic [2:0]  spd,
                                              input logic [10:0] lim);
        logic signed [11:0] d;
        logic signed [11:0] mag;
        logic signed [11:0] stp;
        logic signed [11:0] nxt;
        d   = $signed({1'b0, tgt}) - $signed({1'b0, pos});
        mag = (d < 0) ? -d : d;
        stp = $signed({9'd0, spd});
        if (mag <= stp)
            nxt = $signed({1'b0, tgt});
        else if (d < 0)
            nxt = $signed({1'b0, pos}) - stp;
        else
            nxt = $signed({1'b0, pos}) + stp;
        if (nxt < 0)
            return '0;
        else if (nxt > $signed({1'b0, lim}))
            return lim;
        else
            return nxt[10:0];
    endfunction

endpackage

// File: rtl/ghost_motion_ctrl_frame_tick_gen.sv
// Frame tick generator: one-cycle pulse when the scan x coordinate
// steps from 0 to 1 on scan line V_TICK. Holding x at 1 for several
// clocks still yields a single pulse because x_d1 follows x.
module frame_tick_gen #(
    parameter int V_TICK = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] x,
    input  logic [10:0] y,
    output logic        tick
);

    logic [10:0] x_d1;

    // Delayed copy of x for 0->1 edge detection.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset)
            x_d1 <= '0;
        else
            x_d1 <= x;
    end

    assign tick = (x_d1 == 11'd0) && (x == 11'd1) && (y == 11'(V_TICK));

endmodule

// File: rtl/ghost_motion_ctrl.sv
// Zombie ghost motion/animation sequencer. Once per frame it steps the
// sprite origin toward the target, clamps it to the screen and drives the
// sprite ctrl word through an IDLE/CHASE/STUN state machine.
// Optional build macro GHOST_STUN_FLASH_EN: STUN colour alternates
// yellow/purple every 4 frames; otherwise STUN colour is fixed yellow.
module ghost_motion_ctrl
    import ghost_ctrl_pkg::*;
#(
    parameter int H_MAX       = 608,
    parameter int V_MAX       = 448,
    parameter int V_TICK      = 480,
    parameter int STEP_DIV    = 2,
    parameter int STUN_FRAMES = 60,
    parameter int SPAWN_X     = 304,
    parameter int SPAWN_Y     = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic        en,
    input  logic [10:0] tgt_x,
    input  logic [10:0] tgt_y,
    input  logic [2:0]  speed,
    input  logic        hit,
    input  logic        respawn,
    output logic [10:0] x0,
    output logic [10:0] y0,
    output logic [4:0]  ctrl,
    output logic [1:0]  state,
    output logic        caught
);

    state_t      state_r, state_next;
    logic [10:0] x0_next, y0_next;
    logic [4:0]  ctrl_next;
    logic        caught_next;
    logic [3:0]  div_cnt, div_next;
    logic [7:0]  stun_cnt, stun_next;
    logic [1:0]  stun_color;
    logic        tick;

`ifdef GHOST_STUN_FLASH_EN
    logic [2:0]  flash_cnt, flash_next;
`endif

    frame_tick_gen #(.V_TICK(V_TICK)) u_tick (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .y     (y),
        .tick  (tick)
    );

    // Next-state, next-position and counter logic; respawn > hit > tick.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no
        // path leaves it unassigned and no latch is inferred.
        state_next  = state_r;
        x0_next     = x0;
        y0_next     = y0;
        div_next    = div_cnt;
        stun_next   = stun_cnt;
`ifdef GHOST_STUN_FLASH_EN
        flash_next  = flash_cnt;
`endif
        if (respawn) begin
            state_next = IDLE;
            x0_next    = 11'(SPAWN_X);
            y0_next    = 11'(SPAWN_Y);
            div_next   = '0;
            stun_next  = '0;
`ifdef GHOST_STUN_FLASH_EN
            flash_next = '0;
`endif
        end else if (hit && state_r == CHASE) begin
            state_next = STUN;
            stun_next  = 8'(STUN_FRAMES - 1);
            div_next   = '0;
`ifdef GHOST_STUN_FLASH_EN
            flash_next = '0;
`endif
        end else if (tick) begin
            case (state_r)
                IDLE: begin
                    div_next = '0;
                    if (en)
                        state_next = CHASE;
                end
                CHASE: begin
                    if (!en) begin
                        state_next = IDLE;
                        div_next   = '0;
                    end else if (div_cnt == 4'(STEP_DIV - 1)) begin
                        div_next = '0;
                        x0_next  = axis_step(x0, tgt_x, speed, 11'(H_MAX));
                        y0_next  = axis_step(y0, tgt_y, speed, 11'(V_MAX));
                    end else begin
                        div_next = div_cnt + 4'd1;
                    end
                end
                STUN: begin
`ifdef GHOST_STUN_FLASH_EN
                    flash_next = flash_cnt + 3'd1;
`endif
                    if (stun_cnt == 8'd0)
                        state_next = IDLE;
                    else
                        stun_next = stun_cnt - 8'd1;
                end
                default: state_next = IDLE;
            endcase
        end

`ifdef GHOST_STUN_FLASH_EN
        stun_color = flash_next[2] ? COLOR_PURPLE : COLOR_YELLOW;
`else
        stun_color = COLOR_YELLOW;
`endif
        case (state_next)
            CHASE:   ctrl_next = make_ctrl(COLOR_GREEN, 1'b1, BASE_ID);
            STUN:    ctrl_next = make_ctrl(stun_color, 1'b0, STUN_ID);
            default: ctrl_next = make_ctrl(COLOR_PURPLE, 1'b0, BASE_ID);
        endcase

        caught_next = (state_r == CHASE) && (state_next == CHASE) &&
                      (x0 == tgt_x) && (y0 == tgt_y);
    end

    // Register bank; reset returns to the spawn point in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            x0        <= 11'(SPAWN_X);
            y0        <= 11'(SPAWN_Y);
            ctrl      <= make_ctrl(COLOR_PURPLE, 1'b0, BASE_ID);
            caught    <= 1'b0;
            div_cnt   <= '0;
            stun_cnt  <= '0;
`ifdef GHOST_STUN_FLASH_EN
            flash_cnt <= '0;
`endif
        end else begin
            state_r   <= state_next;
            x0        <= x0_next;
            y0        <= y0_next;
            ctrl      <= ctrl_next;
            caught    <= caught_next;
            div_cnt   <= div_next;
            stun_cnt  <= stun_next;
`ifdef GHOST_STUN_FLASH_EN
            flash_cnt <= flash_next;
`endif
        end
    end

    assign state = state_r;

endmodule
